// File: rtl/wb_pkg.sv
// Shared encodings for the dual-issue writeback stage: load kinds, FSM
// states, byte-enable patterns and the registered slot record.
package wb_pkg;

    localparam logic [2:0] LD_NONE = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;
    localparam logic [2:0] LD_LW   = 3'd5;
    localparam logic [2:0] LD_LWL  = 3'd6;
    localparam logic [2:0] LD_LWR  = 3'd7;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_ALL  = 4'b1111;
    localparam logic [3:0] BE_B3   = 4'b1000;
    localparam logic [3:0] BE_B32  = 4'b1100;
    localparam logic [3:0] BE_B321 = 4'b1110;
    localparam logic [3:0] BE_B210 = 4'b0111;
    localparam logic [3:0] BE_B10  = 4'b0011;
    localparam logic [3:0] BE_B0   = 4'b0001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_W1   = 2'd1,
        ST_W2   = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [2:0]  ld_op;
        logic [1:0]  addr_lo;
        logic [31:0] result;
        logic [31:0] ld_data;
    } wb_slot_t;

    // A slot only touches the regfile if it targets a real GPR.
    function automatic logic slot_writes(input wb_slot_t s);
        return s.gr_we && (s.dest != 5'd0);
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// Per-slot write-data shaping: picks the ALU result or aligns the loaded
// word, and produces the matching regfile byte enables. LWL/LWR leave the
// data pre-shifted into the byte lanes they merge into.
module wb_load_align
    import wb_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] ld_data,
    input  logic [31:0] result,
    output logic [3:0]  we,
    output logic [31:0] wdata
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Extract the addressed byte and halfword from the raw memory word.
    always_comb begin
        ld_byte = ld_data[7:0];
        case (addr_lo)
            2'd0: ld_byte = ld_data[7:0];
            2'd1: ld_byte = ld_data[15:8];
            2'd2: ld_byte = ld_data[23:16];
            2'd3: ld_byte = ld_data[31:24];
            default: ld_byte = ld_data[7:0];
        endcase
        ld_half = addr_lo[1] ? ld_data[31:16] : ld_data[15:0];
    end

    // Select enables and lane-aligned data for the load kind.
    always_comb begin
        we    = BE_ALL;
        wdata = result;
        case (ld_op)
            LD_NONE: wdata = result;
            LD_LB:   wdata = {{24{ld_byte[7]}}, ld_byte};
            LD_LBU:  wdata = {24'd0, ld_byte};
            LD_LH:   wdata = {{16{ld_half[15]}}, ld_half};
            LD_LHU:  wdata = {16'd0, ld_half};
            LD_LW:   wdata = ld_data;
            LD_LWL: begin
                case (addr_lo)
                    2'd0: begin we = BE_B3;   wdata = {ld_data[7:0], 24'd0};  end
                    2'd1: begin we = BE_B32;  wdata = {ld_data[15:0], 16'd0}; end
                    2'd2: begin we = BE_B321; wdata = {ld_data[23:0], 8'd0};  end
                    default: begin we = BE_ALL; wdata = ld_data; end
                endcase
            end
            LD_LWR: begin
                case (addr_lo)
                    2'd0: begin we = BE_ALL;  wdata = ld_data; end
                    2'd1: begin we = BE_B210; wdata = {8'd0, ld_data[31:8]};   end
                    2'd2: begin we = BE_B10;  wdata = {16'd0, ld_data[31:16]}; end
                    default: begin we = BE_B0; wdata = {24'd0, ld_data[31:24]}; end
                endcase
            end
            default: begin
                we    = BE_ALL;
                wdata = result;
            end
        endcase
    end

endmodule

// File: rtl/wb_dual_writer.sv
// Dual-issue writeback stage. Registers a retiring pair from MEM and drives
// the two regfile write ports plus the single trace port.
//
//  state   | meaning
//  IDLE    | nothing pending, ready for a pair
//  W1      | slot1 retiring (and slot2 too when not serialising)
//  W2      | slot2 retiring on its own (serial second half, or slot2-only pair)
module wb_dual_writer
    import wb_pkg::*;
#(
    parameter int SERIAL_TRACE = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        ms_valid_1,
    input  logic        ms_valid_2,
    output logic        ws_allowin,

    input  logic [31:0] ms_pc_1,
    input  logic [31:0] ms_pc_2,
    input  logic        ms_gr_we_1,
    input  logic        ms_gr_we_2,
    input  logic [4:0]  ms_dest_1,
    input  logic [4:0]  ms_dest_2,
    input  logic [2:0]  ms_ld_op_1,
    input  logic [2:0]  ms_ld_op_2,
    input  logic [1:0]  ms_addr_lo_1,
    input  logic [1:0]  ms_addr_lo_2,
    input  logic [31:0] ms_result_1,
    input  logic [31:0] ms_result_2,
    input  logic [31:0] ms_ld_data_1,
    input  logic [31:0] ms_ld_data_2,

    output logic [3:0]  rf_we_1,
    output logic [3:0]  rf_we_2,
    output logic [4:0]  rf_waddr_1,
    output logic [4:0]  rf_waddr_2,
    output logic [31:0] rf_wdata_1,
    output logic [31:0] rf_wdata_2,

    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata
);

    localparam logic SERIAL = (SERIAL_TRACE != 0);

    wb_state_t state, state_nxt;
    logic      slot_v_1, slot_v_2;
    wb_slot_t  slot_1, slot_2;
    wb_slot_t  ms_slot_1, ms_slot_2;

    logic      retire_1, retire_2;
    logic      last_pending;
    logic      accept;
    logic      trace_slot2;

    logic [3:0]  al_we_1, al_we_2;
    logic [31:0] al_wdata_1, al_wdata_2;

    assign ms_slot_1 = '{pc: ms_pc_1, gr_we: ms_gr_we_1, dest: ms_dest_1,
                         ld_op: ms_ld_op_1, addr_lo: ms_addr_lo_1,
                         result: ms_result_1, ld_data: ms_ld_data_1};
    assign ms_slot_2 = '{pc: ms_pc_2, gr_we: ms_gr_we_2, dest: ms_dest_2,
                         ld_op: ms_ld_op_2, addr_lo: ms_addr_lo_2,
                         result: ms_result_2, ld_data: ms_ld_data_2};

    wb_load_align u_align_1 (
        .ld_op   (slot_1.ld_op),
        .addr_lo (slot_1.addr_lo),
        .ld_data (slot_1.ld_data),
        .result  (slot_1.result),
        .we      (al_we_1),
        .wdata   (al_wdata_1)
    );

    wb_load_align u_align_2 (
        .ld_op   (slot_2.ld_op),
        .addr_lo (slot_2.addr_lo),
        .ld_data (slot_2.ld_data),
        .result  (slot_2.result),
        .we      (al_we_2),
        .wdata   (al_wdata_2)
    );

    // Which slots retire this cycle, and whether this cycle empties the stage.
    always_comb begin
        retire_1     = (state == ST_W1) && slot_v_1;
        retire_2     = (((state == ST_W1) && !SERIAL) || (state == ST_W2)) && slot_v_2;
        last_pending = ((state == ST_W1) && !(SERIAL && slot_v_2)) || (state == ST_W2);
        ws_allowin   = (state == ST_IDLE) || last_pending;
        accept       = ws_allowin && (ms_valid_1 || ms_valid_2);
    end

    // Next state: serial split first, then back-to-back accept, else drain to IDLE.
    always_comb begin
        state_nxt = state;
        if ((state == ST_W1) && SERIAL && slot_v_2) begin
            state_nxt = ST_W2;
        end else if (accept) begin
            state_nxt = ms_valid_1 ? ST_W1 : ST_W2;
        end else if (last_pending) begin
            state_nxt = ST_IDLE;
        end
    end

    // State register and pair capture; reset drops anything pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            slot_v_1 <= 1'b0;
            slot_v_2 <= 1'b0;
            slot_1   <= '0;
            slot_2   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                slot_v_1 <= ms_valid_1;
                slot_v_2 <= ms_valid_2;
                slot_1   <= ms_slot_1;
                slot_2   <= ms_slot_2;
            end else if (state_nxt == ST_IDLE) begin
                slot_v_1 <= 1'b0;
                slot_v_2 <= 1'b0;
            end
        end
    end

    // Regfile ports: enables gated by retirement and a real destination.
    always_comb begin
        rf_we_1    = (retire_1 && slot_writes(slot_1)) ? al_we_1 : BE_NONE;
        rf_we_2    = (retire_2 && slot_writes(slot_2)) ? al_we_2 : BE_NONE;
        rf_waddr_1 = slot_1.dest;
        rf_waddr_2 = slot_2.dest;
        rf_wdata_1 = al_wdata_1;
        rf_wdata_2 = al_wdata_2;
    end

    // Trace port: slot2 when it is the one retiring or, in a merged cycle, when it writes.
    always_comb begin
        trace_slot2       = (state == ST_W2) ||
                            (!SERIAL && (state == ST_W1) && (rf_we_2 != BE_NONE));
        debug_wb_pc       = '0;
        debug_wb_rf_wen   = BE_NONE;
        debug_wb_rf_wnum  = '0;
        debug_wb_rf_wdata = '0;
        if (trace_slot2) begin
            debug_wb_pc       = slot_2.pc;
            debug_wb_rf_wen   = rf_we_2;
            debug_wb_rf_wnum  = rf_waddr_2;
            debug_wb_rf_wdata = rf_wdata_2;
        end else if (state == ST_W1) begin
            debug_wb_pc       = slot_1.pc;
            debug_wb_rf_wen   = rf_we_1;
            debug_wb_rf_wnum  = rf_waddr_1;
            debug_wb_rf_wdata = rf_wdata_1;
        end
    end

endmodule

// File: tb/tb_wb_dual_writer.sv
// Bench for wb_dual_writer: a serialising and a merging instance share one
// stimulus stream and are each compared against a slot-level reference model.
module tb_wb_dual_writer;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [2:0]  op;
        logic [1:0]  lo;
        logic [31:0] res;
        logic [31:0] ld;
    } slot_t;

    typedef struct {
        logic [3:0]  we1;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [3:0]  we2;
        logic [4:0]  wa2;
        logic [31:0] wd2;
        logic        ret;
        logic [31:0] dpc;
        logic [3:0]  dwen;
        logic [4:0]  dwnum;
        logic [31:0] dwdata;
        logic        allow;
    } obs_t;

    typedef struct {
        slot_t s;
        int    port;
    } pend_t;

    logic clk = 1'b0;
    logic reset;
    slot_t in_1, in_2;

    logic        s_allowin, p_allowin;
    logic [3:0]  s_rf_we_1, s_rf_we_2, p_rf_we_1, p_rf_we_2;
    logic [4:0]  s_rf_waddr_1, s_rf_waddr_2, p_rf_waddr_1, p_rf_waddr_2;
    logic [31:0] s_rf_wdata_1, s_rf_wdata_2, p_rf_wdata_1, p_rf_wdata_2;
    logic [31:0] s_dbg_pc, p_dbg_pc, s_dbg_wdata, p_dbg_wdata;
    logic [3:0]  s_dbg_wen, p_dbg_wen;
    logic [4:0]  s_dbg_wnum, p_dbg_wnum;

    int n_checks = 0;
    int n_errors = 0;

    pend_t sq[$];
    logic  pv;
    slot_t p1, p2;
    logic  hold;

    always #5 clk = ~clk;

    wb_dual_writer #(.SERIAL_TRACE(1)) dut_s (
        .clk(clk), .reset(reset),
        .ms_valid_1(in_1.v), .ms_valid_2(in_2.v), .ws_allowin(s_allowin),
        .ms_pc_1(in_1.pc), .ms_pc_2(in_2.pc),
        .ms_gr_we_1(in_1.gr_we), .ms_gr_we_2(in_2.gr_we),
        .ms_dest_1(in_1.dest), .ms_dest_2(in_2.dest),
        .ms_ld_op_1(in_1.op), .ms_ld_op_2(in_2.op),
        .ms_addr_lo_1(in_1.lo), .ms_addr_lo_2(in_2.lo),
        .ms_result_1(in_1.res), .ms_result_2(in_2.res),
        .ms_ld_data_1(in_1.ld), .ms_ld_data_2(in_2.ld),
        .rf_we_1(s_rf_we_1), .rf_we_2(s_rf_we_2),
        .rf_waddr_1(s_rf_waddr_1), .rf_waddr_2(s_rf_waddr_2),
        .rf_wdata_1(s_rf_wdata_1), .rf_wdata_2(s_rf_wdata_2),
        .debug_wb_pc(s_dbg_pc), .debug_wb_rf_wen(s_dbg_wen),
        .debug_wb_rf_wnum(s_dbg_wnum), .debug_wb_rf_wdata(s_dbg_wdata)
    );

    wb_dual_writer #(.SERIAL_TRACE(0)) dut_p (
        .clk(clk), .reset(reset),
        .ms_valid_1(in_1.v), .ms_valid_2(in_2.v), .ws_allowin(p_allowin),
        .ms_pc_1(in_1.pc), .ms_pc_2(in_2.pc),
        .ms_gr_we_1(in_1.gr_we), .ms_gr_we_2(in_2.gr_we),
        .ms_dest_1(in_1.dest), .ms_dest_2(in_2.dest),
        .ms_ld_op_1(in_1.op), .ms_ld_op_2(in_2.op),
        .ms_addr_lo_1(in_1.lo), .ms_addr_lo_2(in_2.lo),
        .ms_result_1(in_1.res), .ms_result_2(in_2.res),
        .ms_ld_data_1(in_1.ld), .ms_ld_data_2(in_2.ld),
        .rf_we_1(p_rf_we_1), .rf_we_2(p_rf_we_2),
        .rf_waddr_1(p_rf_waddr_1), .rf_waddr_2(p_rf_waddr_2),
        .rf_wdata_1(p_rf_wdata_1), .rf_wdata_2(p_rf_wdata_2),
        .debug_wb_pc(p_dbg_pc), .debug_wb_rf_wen(p_dbg_wen),
        .debug_wb_rf_wnum(p_dbg_wnum), .debug_wb_rf_wdata(p_dbg_wdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference write shaping from the load rules, using shifts on the whole word.
    function automatic void ref_align(input slot_t s, output logic [3:0] we, output logic [31:0] d);
        int          sh;
        logic [31:0] b, h;
        sh = 8 * int'(s.lo);
        b  = (s.ld >> sh) & 32'hFF;
        h  = (s.ld >> (16 * int'(s.lo[1]))) & 32'hFFFF;
        we = 4'hF;
        case (s.op)
            3'd1: d = b | (b[7] ? 32'hFFFF_FF00 : 32'h0);
            3'd2: d = b;
            3'd3: d = h | (h[15] ? 32'hFFFF_0000 : 32'h0);
            3'd4: d = h;
            3'd5: d = s.ld;
            3'd6: begin we = 4'(4'hF << (3 - int'(s.lo))); d = s.ld << (24 - sh); end
            3'd7: begin we = 4'(4'hF >> s.lo); d = s.ld >> sh; end
            default: d = s.res;
        endcase
        if (!(s.gr_we && s.dest != 0)) we = 4'h0;
    endfunction

    function automatic obs_t idle_obs();
        obs_t o;
        o = '{we1: 0, wa1: 0, wd1: 0, we2: 0, wa2: 0, wd2: 0, ret: 0,
              dpc: 0, dwen: 0, dwnum: 0, dwdata: 0, allow: 1};
        return o;
    endfunction

    function automatic obs_t exp_serial();
        obs_t o;
        o = idle_obs();
        if (sq.size() > 0) begin
            o.ret   = 1;
            o.allow = (sq.size() <= 1);
            o.dpc   = sq[0].s.pc;
            if (sq[0].port == 1) begin
                ref_align(sq[0].s, o.we1, o.wd1);
                o.wa1 = sq[0].s.dest;
                o.dwen = o.we1; o.dwnum = o.wa1; o.dwdata = o.wd1;
            end else begin
                ref_align(sq[0].s, o.we2, o.wd2);
                o.wa2 = sq[0].s.dest;
                o.dwen = o.we2; o.dwnum = o.wa2; o.dwdata = o.wd2;
            end
        end
        return o;
    endfunction

    function automatic obs_t exp_par();
        obs_t o;
        o = idle_obs();
        if (pv) begin
            o.ret = 1;
            if (p1.v) begin ref_align(p1, o.we1, o.wd1); o.wa1 = p1.dest; end
            if (p2.v) begin ref_align(p2, o.we2, o.wd2); o.wa2 = p2.dest; end
            if (o.we2 != 0 || !p1.v) begin
                o.dpc = p2.pc; o.dwen = o.we2; o.dwnum = o.wa2; o.dwdata = o.wd2;
            end else begin
                o.dpc = p1.pc; o.dwen = o.we1; o.dwnum = o.wa1; o.dwdata = o.wd1;
            end
        end
        return o;
    endfunction

    task automatic cmp_obs(input string who, input obs_t g, input obs_t e);
        check({who, " allowin"}, 32'(g.allow), 32'(e.allow));
        check({who, " rf_we_1"}, 32'(g.we1), 32'(e.we1));
        check({who, " rf_we_2"}, 32'(g.we2), 32'(e.we2));
        check({who, " dbg_wen"}, 32'(g.dwen), 32'(e.dwen));
        if (e.we1 != 0) begin
            check({who, " rf_waddr_1"}, 32'(g.wa1), 32'(e.wa1));
            check({who, " rf_wdata_1"}, g.wd1, e.wd1);
        end
        if (e.we2 != 0) begin
            check({who, " rf_waddr_2"}, 32'(g.wa2), 32'(e.wa2));
            check({who, " rf_wdata_2"}, g.wd2, e.wd2);
        end
        if (e.ret) check({who, " dbg_pc"}, g.dpc, e.dpc);
        if (e.dwen != 0) begin
            check({who, " dbg_wnum"}, 32'(g.dwnum), 32'(e.dwnum));
            check({who, " dbg_wdata"}, g.dwdata, e.dwdata);
        end
    endtask

    task automatic compare_all();
        obs_t gs, gp;
        gs = '{we1: s_rf_we_1, wa1: s_rf_waddr_1, wd1: s_rf_wdata_1,
               we2: s_rf_we_2, wa2: s_rf_waddr_2, wd2: s_rf_wdata_2, ret: 1'b0,
               dpc: s_dbg_pc, dwen: s_dbg_wen, dwnum: s_dbg_wnum, dwdata: s_dbg_wdata,
               allow: s_allowin};
        gp = '{we1: p_rf_we_1, wa1: p_rf_waddr_1, wd1: p_rf_wdata_1,
               we2: p_rf_we_2, wa2: p_rf_waddr_2, wd2: p_rf_wdata_2, ret: 1'b0,
               dpc: p_dbg_pc, dwen: p_dbg_wen, dwnum: p_dbg_wnum, dwdata: p_dbg_wdata,
               allow: p_allowin};
        cmp_obs("serial", gs, exp_serial());
        cmp_obs("merged", gp, exp_par());
    endtask

    // Advance both models across the coming clock edge using the current inputs.
    task automatic model_edge();
        logic sa;
        sa = (sq.size() <= 1);
        if (sq.size() > 0) void'(sq.pop_front());
        if (sa && (in_1.v || in_2.v)) begin
            if (in_1.v) sq.push_back('{s: in_1, port: 1});
            if (in_2.v) sq.push_back('{s: in_2, port: 2});
        end
        hold = !sa && (in_1.v || in_2.v);
        pv = in_1.v || in_2.v;
        p1 = in_1;
        p2 = in_2;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    function automatic slot_t mk(input logic v, input logic [31:0] pc, input logic gr_we,
                                 input logic [4:0] dest, input logic [2:0] op,
                                 input logic [1:0] lo, input logic [31:0] res,
                                 input logic [31:0] ld);
        slot_t s;
        s = '{v: v, pc: pc, gr_we: gr_we, dest: dest, op: op, lo: lo, res: res, ld: ld};
        return s;
    endfunction

    function automatic slot_t rnd_slot(input logic v);
        return mk(v, $urandom, 1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 2'($urandom), $urandom, $urandom);
    endfunction

    task automatic go_idle();
        in_1 = mk(0, 0, 0, 0, 0, 0, 0, 0);
        in_2 = mk(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int r;
        reset = 1'b1;
        hold  = 1'b0;
        pv    = 1'b0;
        go_idle();
        p1 = in_1;
        p2 = in_2;
        @(negedge clk);
        @(negedge clk);
        compare_all();
        reset = 1'b0;

        for (int i = 0; i < 1500; i++) begin
            if (!hold) begin
                r = $urandom_range(0, 7);
                in_1 = rnd_slot(r != 0 && r != 2);
                in_2 = rnd_slot(r != 0 && r != 1);
            end
            tick();
        end
        go_idle();
        tick();
        tick();

        // Serial pair: port1 then port2, stall in between.
        in_1 = mk(1, 32'h100, 1, 3, 3'd0, 0, 32'h11, 0);
        in_2 = mk(1, 32'h104, 1, 5, 3'd0, 0, 32'h22, 0);
        tick();
        go_idle();
        check("pair c1 waddr_1", 32'(s_rf_waddr_1), 32'd3);
        check("pair c1 wdata_1", s_rf_wdata_1, 32'h11);
        check("pair c1 we_1", 32'(s_rf_we_1), 32'hF);
        check("pair c1 we_2", 32'(s_rf_we_2), 32'h0);
        check("pair c1 allowin", 32'(s_allowin), 32'd0);
        tick();
        check("pair c2 waddr_2", 32'(s_rf_waddr_2), 32'd5);
        check("pair c2 wdata_2", s_rf_wdata_2, 32'h22);
        check("pair c2 allowin", 32'(s_allowin), 32'd1);
        tick();

        // LB / LBU from lane 2.
        in_1 = mk(1, 32'h110, 1, 4, 3'd1, 2, 0, 32'h1280_5634);
        in_2 = mk(1, 32'h114, 1, 6, 3'd2, 2, 0, 32'h1280_5634);
        tick();
        go_idle();
        check("lb wdata", p_rf_wdata_1, 32'hFFFF_FF80);
        check("lbu wdata", p_rf_wdata_2, 32'h0000_0080);
        check("lb we", 32'(p_rf_we_1), 32'hF);
        tick();
        tick();

        // LWL / LWR partial merges.
        in_1 = mk(1, 32'h120, 1, 8, 3'd6, 1, 0, 32'hAABB_CCDD);
        in_2 = mk(1, 32'h124, 1, 9, 3'd7, 2, 0, 32'hAABB_CCDD);
        tick();
        go_idle();
        check("lwl we", 32'(p_rf_we_1), 32'hC);
        check("lwl wdata", p_rf_wdata_1, 32'hCCDD_0000);
        check("lwr we", 32'(p_rf_we_2), 32'h3);
        check("lwr wdata", p_rf_wdata_2, 32'h0000_AABB);
        tick();
        tick();

        // Same destination in the merging instance: trace shows slot2.
        in_1 = mk(1, 32'h200, 1, 7, 3'd0, 0, 32'hA, 0);
        in_2 = mk(1, 32'h204, 1, 7, 3'd0, 0, 32'hB, 0);
        tick();
        go_idle();
        check("samedst waddr_1", 32'(p_rf_waddr_1), 32'd7);
        check("samedst waddr_2", 32'(p_rf_waddr_2), 32'd7);
        check("samedst dbg_pc", p_dbg_pc, 32'h204);
        tick();
        tick();

        // dest 0 suppresses the write; then a slot2-only pair.
        in_1 = mk(1, 32'h300, 1, 0, 3'd0, 0, 32'h77, 0);
        tick();
        check("dest0 we_1", 32'(s_rf_we_1), 32'h0);
        check("dest0 dbg_wen", 32'(s_dbg_wen), 32'h0);
        go_idle();
        in_2 = mk(1, 32'h304, 1, 10, 3'd0, 0, 32'h55, 0);
        tick();
        go_idle();
        check("s2only we_2", 32'(s_rf_we_2), 32'hF);
        check("s2only waddr_2", 32'(s_rf_waddr_2), 32'd10);
        check("s2only we_1", 32'(s_rf_we_1), 32'h0);
        check("s2only allowin", 32'(s_allowin), 32'd1);
        tick();

        // Reset in the middle of a serial pair.
        in_1 = mk(1, 32'h400, 1, 3, 3'd0, 0, 32'h11, 0);
        in_2 = mk(1, 32'h404, 1, 5, 3'd0, 0, 32'h22, 0);
        tick();
        go_idle();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst we_1", 32'(s_rf_we_1), 32'h0);
        check("rst we_2", 32'(s_rf_we_2), 32'h0);
        check("rst dbg_wen", 32'(s_dbg_wen), 32'h0);
        check("rst allowin", 32'(s_allowin), 32'd1);
        sq.delete();
        pv = 1'b0;
        reset = 1'b0;
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
